// File: rtl/hgw_pkg.sv
// rtl/hgw_pkg.sv - shared types and width helpers for the hgw datapath blocks
package hgw_pkg;

  // Integrate-and-dump control states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Accumulator width that cannot overflow for any frame of up to 2^nw-1 samples
  function automatic int acc_width(input int iw, input int nw);
    return iw + nw;
  endfunction

endpackage

// File: rtl/hgw_sat_signed.sv
// rtl/hgw_sat_signed.sv - symmetric signed saturator, never emits the most-negative code
module hgw_sat_signed #(
  parameter int I_W = 21,
  parameter int O_W = 15
) (
  input  logic signed [I_W-1:0] d,
  output logic signed [O_W-1:0] q
);

  localparam int MAXI = (1 << (O_W - 1)) - 1;
  localparam logic signed [I_W-1:0] HI = MAXI[I_W-1:0];
  localparam logic signed [I_W-1:0] LO = -HI;
  localparam logic signed [O_W-1:0] Q_HI = MAXI[O_W-1:0];
  localparam logic signed [O_W-1:0] Q_LO = -Q_HI;

  // Clip to +/-(2^(O_W-1)-1); in-range values pass through unchanged
  always_comb begin
    q = d[O_W-1:0];
    if (d > HI) begin
      q = Q_HI;
    end else if (d < LO) begin
      q = Q_LO;
    end
  end

endmodule

// File: rtl/hgw_acc_dump_rnd.sv
// rtl/hgw_acc_dump_rnd.sv - signed integrate-and-dump with round-half-up shift and symmetric saturation
module hgw_acc_dump_rnd
  import hgw_pkg::*;
#(
  parameter int I_W  = 12,
  parameter int N_W  = 8,
  parameter int SH_W = 4,
  parameter int O_W  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [N_W-1:0]        len,
  input  logic [SH_W-1:0]       shift,
  input  logic                  i_vld,
  output logic                  i_rdy,
  input  logic signed [I_W-1:0] i_dat,
  output logic                  o_vld,
  input  logic                  o_rdy,
  output logic signed [O_W-1:0] o_dat,
  output logic                  o_sat
);

  localparam int ACC_W = acc_width(I_W, N_W);
  localparam int MAXI  = (1 << (O_W - 1)) - 1;
  localparam logic signed [ACC_W:0] MAXR = MAXI[ACC_W:0];
  localparam logic signed [ACC_W:0] MINR = -MAXR;
  localparam logic signed [ACC_W:0] ONE  = 1;

  state_t                  state;
  logic [N_W-1:0]          cnt;
  logic [N_W-1:0]          len_q;
  logic [SH_W-1:0]         shift_q;
  logic signed [ACC_W-1:0] acc;

  logic                    accept;
  logic [N_W-1:0]          len_eff;
  logic [N_W-1:0]          cnt_nxt;
  logic [SH_W-1:0]         shift_eff;
  logic                    last;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   sum_x;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   r;
  logic signed [O_W-1:0]   r_sat;
  logic                    clip;

  // A pending result that is not being taken blocks new samples
  assign i_rdy  = ~(o_vld & ~o_rdy);
  assign accept = i_vld & i_rdy;

  // Frame parameters: live inputs on the first sample, latched copies afterwards
  always_comb begin
    len_eff   = (len == '0) ? N_W'(1) : len;
    cnt_nxt   = cnt + N_W'(1);
    shift_eff = (state == ST_IDLE) ? shift : shift_q;
    last      = (state == ST_IDLE) ? (len_eff == N_W'(1)) : (cnt_nxt == len_q);
  end

  // Final sum, round-half-up and arithmetic shift in one extra bit of headroom
  always_comb begin
    sum   = acc + {{N_W{i_dat[I_W-1]}}, i_dat};
    sum_x = {sum[ACC_W-1], sum};
    rnd   = (shift_eff == '0) ? '0 : (ONE << (shift_eff - SH_W'(1)));
    r     = (sum_x + rnd) >>> shift_eff;
    clip  = (r > MAXR) || (r < MINR);
  end

  hgw_sat_signed #(
    .I_W(ACC_W + 1),
    .O_W(O_W)
  ) u_sat (
    .d(r),
    .q(r_sat)
  );

  // Frame FSM with registered result; clr aborts the frame and drops any pending output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      shift_q <= '0;
      acc     <= '0;
      o_vld   <= 1'b0;
      o_dat   <= '0;
      o_sat   <= 1'b0;
    end else if (clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      o_vld <= 1'b0;
    end else begin
      if (o_vld && o_rdy) begin
        o_vld <= 1'b0;
      end
      if (accept) begin
        if (state == ST_IDLE) begin
          len_q   <= len_eff;
          shift_q <= shift;
        end
        if (last) begin
          state <= ST_IDLE;
          acc   <= '0;
          cnt   <= '0;
          o_vld <= 1'b1;
          o_dat <= r_sat;
          o_sat <= clip;
        end else begin
          state <= ST_ACC;
          acc   <= sum;
          cnt   <= (state == ST_IDLE) ? N_W'(1) : cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_hgw_acc_dump_rnd.sv
// tb/tb_hgw_acc_dump_rnd.sv - scoreboard bench for the integrate-and-dump stage
module tb_hgw_acc_dump_rnd;

  localparam int I_W  = 12;
  localparam int N_W  = 8;
  localparam int SH_W = 4;
  localparam int O_W  = 15;

  logic                  clk;
  logic                  rst_n;
  logic                  clr;
  logic [N_W-1:0]        len;
  logic [SH_W-1:0]       shift;
  logic                  i_vld;
  logic                  i_rdy;
  logic signed [I_W-1:0] i_dat;
  logic                  o_vld;
  logic                  o_rdy;
  logic signed [O_W-1:0] o_dat;
  logic                  o_sat;

  int errors = 0;
  int checks = 0;
  int exp_dat_q[$];
  int exp_sat_q[$];

  hgw_acc_dump_rnd #(
    .I_W(I_W), .N_W(N_W), .SH_W(SH_W), .O_W(O_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .len(len), .shift(shift),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_sat(o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_result(input int d, input int s);
    exp_dat_q.push_back(d);
    exp_sat_q.push_back(s);
  endtask

  // Monitor: compare every completed output handshake against the scoreboard
  always @(negedge clk) begin
    if (rst_n && o_vld) begin
      check("no_min_code", (int'(o_dat) == -16384) ? 1 : 0, 0);
      if (o_rdy) begin
        if (exp_dat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", o_dat);
        end else begin
          check("o_dat", int'(o_dat), exp_dat_q.pop_front());
          check("o_sat", int'(o_sat), exp_sat_q.pop_front());
        end
      end
    end
  end

  task automatic send(input int v);
    bit ok;
    ok = 0;
    i_vld = 1'b1;
    i_dat = v[I_W-1:0];
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i_rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_vld = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_o_vld", int'(o_vld), 0);
    check("rst_o_dat", int'(o_dat), 0);
    check("rst_o_sat", int'(o_sat), 0);
    check("rst_i_rdy", int'(i_rdy), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    len   = '0;
    shift = '0;
    i_vld = 1'b0;
    i_dat = '0;
    o_rdy = 1'b1;
    #1;
    check("reset_o_vld", int'(o_vld), 0);
    check("reset_o_dat", int'(o_dat), 0);
    check("reset_o_sat", int'(o_sat), 0);
    check("reset_i_rdy", int'(i_rdy), 1);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic rounding: (406 + 2) >> 2 = 102, visible right after last sample
    len = 8'd4; shift = 4'd2;
    expect_result(102, 0);
    send(100); send(101); send(102);
    check("no_early_vld", int'(o_vld), 0);
    send(103);
    check("latency_o_vld", int'(o_vld), 1);
    @(posedge clk); #1;

    // Negative round-half-up, len=1 back-to-back
    len = 8'd1; shift = 4'd1;
    expect_result(-1, 0);
    expect_result(-2, 0);
    send(-3); send(-4);
    @(posedge clk); #1;

    // len=0 treated as 1, shift 0 passthrough
    len = 8'd0; shift = 4'd0;
    expect_result(-7, 0);
    send(-7);
    @(posedge clk); #1;

    // Positive saturation: 255 * 2047 = 521985
    len = 8'd255; shift = 4'd0;
    expect_result(16383, 1);
    for (int k = 0; k < 255; k++) send(2047);
    @(posedge clk); #1;

    // Negative saturation: 255 * -2048 = -522240
    expect_result(-16383, 1);
    for (int k = 0; k < 255; k++) send(-2048);
    @(posedge clk); #1;

    // Backpressure: pending 30 stalls the input and holds the output
    len = 8'd2; shift = 4'd0;
    o_rdy = 1'b0;
    expect_result(30, 0);
    send(10); send(20);
    i_vld = 1'b1;
    i_dat = 12'sd5;
    len = 8'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_i_rdy", int'(i_rdy), 0);
      check("bp_o_dat_hold", int'(o_dat), 30);
      check("bp_o_vld_hold", int'(o_vld), 1);
    end
    @(posedge clk); #1;
    len = 8'd2;
    o_rdy = 1'b1;
    expect_result(12, 0);
    send(5); send(7);
    @(posedge clk); #1;

    // clr mid-frame: no output, concurrent sample dropped, next frame clean
    len = 8'd8; shift = 4'd3;
    send(1); send(1); send(1);
    clr = 1'b1; i_vld = 1'b1; i_dat = 12'sd100;
    @(posedge clk); #1;
    clr = 1'b0; i_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("clr_no_vld", int'(o_vld), 0);
    end
    @(posedge clk); #1;
    expect_result(1, 0);
    for (int k = 0; k < 8; k++) send(1);
    @(posedge clk); #1;

    // Asynchronous reset mid-frame
    len = 8'd8; shift = 4'd3;
    send(1); send(1); send(1);
    async_reset();

    // Asynchronous reset discards a pending output
    o_rdy = 1'b0;
    len = 8'd1; shift = 4'd0;
    send(50);
    @(negedge clk);
    check("pend_o_vld", int'(o_vld), 1);
    async_reset();
    o_rdy = 1'b1;

    // Accumulator was cleared: 4 * 10 = 40
    len = 8'd4; shift = 4'd0;
    expect_result(40, 0);
    for (int k = 0; k < 4; k++) send(10);
    repeat (4) @(posedge clk);
    #1;

    check("scoreboard_empty", exp_dat_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
